// File: rtl/spi_cmd_decoder_pkg.sv
// ============================================================================
// Module   : spi_cmd_decoder_pkg
// Brief    : Opcodes and state encodings shared by the SPI command decoder.
// Revision : 1.0
// ============================================================================
`default_nettype none

package spi_cmd_decoder_pkg;

    localparam logic [3:0] CMD_SETADDR = 4'h1;
    localparam logic [3:0] CMD_WRITE   = 4'h2;
    localparam logic [3:0] CMD_READ    = 4'h3;
    localparam logic [3:0] CMD_STATUS  = 4'h4;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        WRITE  = 3'd2,
        READ   = 3'd3,
        STATUS = 3'd4,
        IGNORE = 3'd5
    } msg_state_t;

    typedef enum logic [0:0] {
        MIDLE = 1'b0,
        MWAIT = 1'b1
    } mem_state_t;

    function automatic msg_state_t decode_cmd(input logic [3:0] op);
        case (op)
            CMD_SETADDR: decode_cmd = ADDR;
            CMD_WRITE:   decode_cmd = WRITE;
            CMD_READ:    decode_cmd = READ;
            CMD_STATUS:  decode_cmd = STATUS;
            default:     decode_cmd = IGNORE;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/spi_mem_port.sv
// ============================================================================
// Module   : spi_mem_port
// Brief    : Single-outstanding memory request FSM with request hold registers.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_mem_port
    import spi_cmd_decoder_pkg::*;
#(
    parameter int ADDR_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_issue,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [7:0]        i_wdata,
    input  logic              i_mem_ack,
    output logic              o_mem_req,
    output logic              o_mem_we,
    output logic [ADDR_W-1:0] o_mem_addr,
    output logic [7:0]        o_mem_wdata,
    output logic              o_busy,
    output logic              o_done
);

    mem_state_t        r_state;
    mem_state_t        w_state_next;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [7:0]        r_wdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= MIDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            MIDLE:   if (i_issue)   w_state_next = MWAIT;
            MWAIT:   if (i_mem_ack) w_state_next = MIDLE;
            default: w_state_next = MIDLE;
        endcase
    end

    // Hold registers only load from MIDLE so they stay frozen while requesting.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= 8'h00;
        end else if (r_state == MIDLE && i_issue) begin
            r_we    <= i_we;
            r_addr  <= i_addr;
            r_wdata <= i_wdata;
        end
    end

    assign o_mem_req   = (r_state == MWAIT);
    assign o_busy      = (r_state == MWAIT);
    assign o_done      = (r_state == MWAIT) && i_mem_ack;
    assign o_mem_we    = r_we;
    assign o_mem_addr  = r_addr;
    assign o_mem_wdata = r_wdata;

endmodule

`default_nettype wire

// File: rtl/spi_cmd_decoder.sv
// ============================================================================
// Module   : spi_cmd_decoder
// Brief    : Decodes SPI command/parameter bytes into address, memory and status ops.
// Revision : 1.0
// ============================================================================
`default_nettype none

module spi_cmd_decoder
    import spi_cmd_decoder_pkg::*;
#(
    parameter int ADDR_W = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_ready,
    input  logic              param_ready,
    input  logic [7:0]        cmd_data,
    input  logic [7:0]        param_data,
    input  logic              startmessage,
    input  logic              endmessage,
    output logic [7:0]        spi_out_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ack,
    input  logic [7:0]        mem_rdata,
    output logic              overrun
);

    msg_state_t        r_msg;
    msg_state_t        w_msg_next;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_next;
    logic [1:0]        r_cnt;
    logic [7:0]        r_spi_out;
    logic              r_overrun;

    logic [3:0]        w_op;
    logic              w_cmd;
    logic              w_param;
    logic              w_mem_param;
    logic              w_cmd_read;
    logic              w_issue;
    logic              w_issue_we;
    logic              w_drop;
    logic              w_busy;
    logic              w_done;

    assign w_op        = cmd_data[7:4];
    assign w_cmd       = cmd_ready && (r_msg == IDLE) && !startmessage && !endmessage;
    assign w_param     = param_ready && !cmd_ready;
    assign w_mem_param = w_param && ((r_msg == WRITE) || (r_msg == READ));
    assign w_cmd_read  = w_cmd && (w_op == CMD_READ);
    assign w_issue     = (w_cmd_read || w_mem_param) && !w_busy;
    assign w_issue_we  = !w_cmd && (r_msg == WRITE);
    assign w_drop      = (w_cmd_read || w_mem_param) && w_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_msg <= IDLE;
        end else begin
            r_msg <= w_msg_next;
        end
    end

    always_comb begin
        w_msg_next = r_msg;
        if (startmessage || endmessage) begin
            w_msg_next = IDLE;
        end else if (r_msg == IDLE && cmd_ready) begin
            w_msg_next = decode_cmd(w_op);
        end
    end

    // An ack increment and a SET_ADDR byte load can coincide when a previous
    // message's access completes late; both are merged here.
    always_comb begin
        w_addr_next = w_done ? r_addr + {{(ADDR_W-1){1'b0}}, 1'b1} : r_addr;
        if (w_param && r_msg == ADDR) begin
            case (r_cnt)
                2'd0:    w_addr_next[23:16] = param_data;
                2'd1:    w_addr_next[15:8]  = param_data;
                2'd2:    w_addr_next[7:0]   = param_data;
                default: w_addr_next        = w_addr_next;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr    <= '0;
            r_cnt     <= 2'd0;
            r_spi_out <= 8'h00;
            r_overrun <= 1'b0;
        end else begin
            r_addr <= w_addr_next;

            if (w_cmd) begin
                r_cnt <= 2'd0;
            end else if (w_param && r_cnt != 2'd3) begin
                r_cnt <= r_cnt + 2'd1;
            end

            if (w_cmd && w_op == CMD_STATUS) begin
                r_spi_out <= {r_overrun, mem_req, 6'b0};
            end else if (w_cmd && decode_cmd(w_op) == IGNORE) begin
                r_spi_out <= 8'h00;
            end else if (w_done && !mem_we) begin
                r_spi_out <= mem_rdata;
            end

            if (endmessage && r_msg == STATUS) begin
                r_overrun <= 1'b0;
            end else if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    spi_mem_port #(
        .ADDR_W (ADDR_W)
    ) u_mem_port (
        .clk         (clk),
        .rst         (rst),
        .i_issue     (w_issue),
        .i_we        (w_issue_we),
        .i_addr      (r_addr),
        .i_wdata     (param_data),
        .i_mem_ack   (mem_ack),
        .o_mem_req   (mem_req),
        .o_mem_we    (mem_we),
        .o_mem_addr  (mem_addr),
        .o_mem_wdata (mem_wdata),
        .o_busy      (w_busy),
        .o_done      (w_done)
    );

    assign spi_out_data = r_spi_out;
    assign overrun      = r_overrun;

endmodule

`default_nettype wire
